// File: rtl/snake_pkg.sv
// Shared codes for the snake game: headings, game_ctrl states, and helpers.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [2:0] {
        GS_RESTART = 3'b000,
        GS_START   = 3'b001,
        GS_PLAY    = 3'b010,
        GS_DIE     = 3'b011
    } game_status_e;

    // Opposite headings share the axis bit and differ only in bit0.
    function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

    // max(base - lvl*step, floor), evaluated wide enough that it cannot wrap.
    function automatic logic [31:0] calc_period(input logic [31:0] lvl,
                                                input logic [31:0] base,
                                                input logic [31:0] step,
                                                input logic [31:0] floor);
        logic [63:0] dec;
        dec = 64'(lvl) * 64'(step);
        if (dec + 64'(floor) >= 64'(base)) begin
            return floor;
        end
        return base - 32'(dec);
    endfunction

endpackage

// File: rtl/snake_dir_fifo.sv
// Small FIFO of 2-bit headings; exposes both head and most recent entry (tail).
module snake_dir_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [1:0]                 din,
    output logic [1:0]                 head,
    output logic [1:0]                 tail,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [1:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] count_q;

    // Flush wins over push/pop; push+pop on a full FIFO overwrites the slot being popped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 2'b00;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= din;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem_q[rd_q];
    assign tail  = mem_q[wr_q - AW'(1)];
    assign count = count_q;

endmodule

// File: rtl/snake_move_sched.sv
// Snake motion scheduler: turn-request queue, move tick generation, speed level.
// Optional speed-up by level is enabled with `define SNAKE_SPEEDUP_EN.
module snake_move_sched
    import snake_pkg::*;
#(
    parameter int unsigned TICK_BASE        = 25_000_000,
    parameter int unsigned TICK_STEP        = 2_000_000,
    parameter int unsigned TICK_MIN         = 5_000_000,
    parameter int unsigned FIFO_DEPTH       = 4,
    parameter int unsigned APPLES_PER_LEVEL = 5,
    parameter int unsigned LEVEL_W          = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          key_up,
    input  logic                          key_down,
    input  logic                          key_left,
    input  logic                          key_right,
    input  logic                          add_cube,
    input  logic [2:0]                    game_status,
    output logic                          move_tick,
    output logic [1:0]                    dir,
    output logic [LEVEL_W-1:0]            level,
    output logic [$clog2(FIFO_DEPTH):0]   q_count,
    output logic                          req_drop
);

    localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNT_W = 32;

    logic             play_c, restart_c;
    logic             req_valid_c, lost_c, bad_c, full_c;
    logic [1:0]       req_dir_c, tail_ref_c;
    logic             fire_c, push_c, pop_c, flush_c;
    logic [1:0]       fifo_head, fifo_tail;
    logic [CW-1:0]    fifo_count;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               move_tick_q, move_tick_d;
    logic [1:0]         dir_q, dir_d;
    logic               req_drop_q, req_drop_d;
    logic [LEVEL_W-1:0] level_q, level_d;

    assign play_c    = (game_status == GS_PLAY);
    assign restart_c = (game_status == GS_RESTART);

    // Fixed-priority key pick: up > down > left > right; losers count as drops.
    always_comb begin
        req_valid_c = 1'b1;
        req_dir_c   = DIR_RIGHT;
        lost_c      = 1'b0;
        if (key_up) begin
            req_dir_c = DIR_UP;
            lost_c    = key_down | key_left | key_right;
        end else if (key_down) begin
            req_dir_c = DIR_DOWN;
            lost_c    = key_left | key_right;
        end else if (key_left) begin
            req_dir_c = DIR_LEFT;
            lost_c    = key_right;
        end else if (key_right) begin
            req_dir_c = DIR_RIGHT;
        end else begin
            req_valid_c = 1'b0;
        end
    end

    assign fire_c     = play_c && (cnt_q >= period_q - CNT_W'(1));
    assign pop_c      = fire_c && (fifo_count != '0);
    assign full_c     = (fifo_count == CW'(FIFO_DEPTH));
    assign tail_ref_c = (fifo_count != '0) ? fifo_tail : dir_q;
    assign bad_c      = (req_dir_c == tail_ref_c) || is_opposite(req_dir_c, tail_ref_c)
                        || (full_c && !pop_c);
    assign push_c     = play_c && req_valid_c && !bad_c;
    assign flush_c    = !play_c;

    snake_dir_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .pop   (pop_c),
        .flush (flush_c),
        .din   (req_dir_c),
        .head  (fifo_head),
        .tail  (fifo_tail),
        .count (fifo_count)
    );

    // Tick counter, heading update and drop pulse.
    always_comb begin
        cnt_d       = '0;
        move_tick_d = fire_c;
        dir_d       = dir_q;
        req_drop_d  = play_c && ((req_valid_c && bad_c) || lost_c);
        if (play_c && !fire_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (restart_c) begin
            dir_d = DIR_RIGHT;
        end else if (pop_c) begin
            dir_d = fifo_head;
        end
    end

`ifdef SNAKE_SPEEDUP_EN
    localparam int unsigned AP_W = $clog2(APPLES_PER_LEVEL + 1);

    logic [AP_W-1:0] apple_q, apple_d;

    // Apple counter wraps at APPLES_PER_LEVEL and bumps a saturating level.
    always_comb begin
        apple_d = apple_q;
        level_d = level_q;
        if (restart_c) begin
            apple_d = '0;
            level_d = '0;
        end else if (play_c && add_cube) begin
            if (apple_q == AP_W'(APPLES_PER_LEVEL - 1)) begin
                apple_d = '0;
                if (level_q != '1) begin
                    level_d = level_q + LEVEL_W'(1);
                end
            end else begin
                apple_d = apple_q + AP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            apple_q <= '0;
        end else begin
            apple_q <= apple_d;
        end
    end

    assign period_d = calc_period(32'(level_q), 32'(TICK_BASE), 32'(TICK_STEP), 32'(TICK_MIN));
`else
    logic [32:0] unused_cfg;

    assign unused_cfg = {add_cube, 32'(TICK_STEP) ^ 32'(TICK_MIN) ^ 32'(APPLES_PER_LEVEL)};
    assign level_d    = '0;
    assign period_d   = CNT_W'(TICK_BASE);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            period_q    <= CNT_W'(TICK_BASE);
            move_tick_q <= 1'b0;
            dir_q       <= DIR_RIGHT;
            req_drop_q  <= 1'b0;
            level_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            move_tick_q <= move_tick_d;
            dir_q       <= dir_d;
            req_drop_q  <= req_drop_d;
            level_q     <= level_d;
        end
    end

    assign move_tick = move_tick_q;
    assign dir       = dir_q;
    assign level     = level_q;
    assign q_count   = fifo_count;
    assign req_drop  = req_drop_q;

endmodule
